// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one memory port between NM masters with timeout abort
module mem_bus_arbiter #(
  parameter int NM = 3,
  parameter logic [7:0] TOUT = 8'd255,
  parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic [NM-1:0]    iReq,
  input  logic [NM-1:0]    iWe,
  input  logic [4*NM-1:0]  iByteEnable,
  input  logic [32*NM-1:0] iAddress,
  input  logic [32*NM-1:0] iWriteData,
  output logic [NM-1:0]  oAck,
  output logic           oError,
  output logic [31:0]    oReadData,
  output logic [NM-1:0]  oGrant,
  output logic           oMemReadEnable,
  output logic           oMemWriteEnable,
  output logic [3:0]     oMemByteEnable,
  output logic [31:0]    oMemAddress,
  output logic [31:0]    oMemWriteData,
  input  logic           iMemReady,
  input  logic [31:0]    iMemReadData
);
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, gidx_q, gidx_d, pick;
  logic [NM-1:0] grant_q, grant_d, ack_q, ack_d, elig;
  logic [7:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d, found, done;
  logic [3:0] be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NM);
  endfunction
  always_comb begin
    elig = iReq & ~ack_q;
    pick = '0;
    found = 1'b0;
    for (int i = NM-1; i >= 0; i--)
      if (elig[wrap(int'(ptr_q) + i)]) begin
        pick = wrap(int'(ptr_q) + i);
        found = 1'b1;
      end
  end
  // Ready beats timeout when both happen in the same cycle.
  assign done = (state_q == ACCESS) && (iMemReady || cnt_q == TOUT);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gidx_d = gidx_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    we_d = we_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d = '0;
    err_d = 1'b0;
    if (state_q == IDLE && found) begin
      state_d = ACCESS;
      gidx_d = pick;
      grant_d = NM'(1) << pick;
      cnt_d = '0;
      we_d = iWe[pick];
      be_d = iByteEnable[4*pick +: 4];
      addr_d = iAddress[32*pick +: 32];
      wdata_d = iWriteData[32*pick +: 32];
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + 8'd1;
      if (done) begin
        state_d = IDLE;
        ack_d = grant_q;
        err_d = ~iMemReady;
        rdata_d = !iMemReady ? ERRDATA : we_q ? '0 : iMemReadData;
        ptr_d = wrap(int'(gidx_q) + 1);
        grant_d = '0;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gidx_q <= '0;
      grant_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gidx_q <= gidx_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end
  assign oAck = ack_q;
  assign oError = err_q;
  assign oReadData = rdata_q;
  assign oGrant = grant_q;
  assign oMemReadEnable = (state_q == ACCESS) & ~we_q;
  assign oMemWriteEnable = (state_q == ACCESS) & we_q;
  assign oMemByteEnable = be_q;
  assign oMemAddress = addr_q;
  assign oMemWriteData = wdata_q;
endmodule
